// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential floating-point multiplier.
// Holds round-mode codes, FSM states, operand classes and derived-width helpers.
package fp_mul_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RND  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_t;

  function automatic int calc_w(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Subnormals have a zero exponent and are treated as zero on input.
  function automatic fclass_t classify(input logic exp_zero, input logic exp_ones,
                                       input logic frac_zero);
    if (exp_zero)      return CLS_ZERO;
    else if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    else               return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand-issue and result-writeback handshake bundle for fp_mul_seq.
// master = issue/writeback side, slave = the multiplier.
interface fp_mul_seq_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_invalid;
  logic         flag_overflow;
  logic         flag_underflow;
  logic         flag_inexact;

  modport master (
    output in_valid, a, b, round_mode, out_ready,
    input  in_ready, out_valid, result,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  in_valid, a, b, round_mode, out_ready,
    output in_ready, out_valid, result,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational round/pack stage: normalised significand plus guard/round/sticky
// in, packed IEEE word and overflow/underflow/inexact out (flush-to-zero).
module fp_round_pack
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    i_sign,
  input  logic [EXP_W+1:0]        i_exp,
  input  logic [FRAC_W:0]         i_sig,
  input  logic                    i_guard,
  input  logic                    i_round,
  input  logic                    i_sticky,
  input  logic [1:0]              i_round_mode,
  output logic [EXP_W+FRAC_W:0]   o_result,
  output logic                    o_overflow,
  output logic                    o_underflow,
  output logic                    o_inexact
);
  localparam int EW = EXP_W + 2;
  localparam int SW = FRAC_W + 1;
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  logic              w_lost;
  logic              w_inc;
  logic              w_to_inf;
  logic [SW:0]       w_sum;
  logic [FRAC_W-1:0] w_frac;
  logic [EW-1:0]     w_exp;

  assign w_lost = i_guard | i_round | i_sticky;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_inc = 1'b0;
    case (i_round_mode)
      RM_RNE:  w_inc = i_guard & (i_round | i_sticky | i_sig[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = w_lost & ~i_sign;
      RM_RDN:  w_inc = w_lost & i_sign;
      default: w_inc = 1'b0;
    endcase
  end

  // A carry out of the increment leaves 1.000..0, so shift right and bump the exponent.
  assign w_sum  = {1'b0, i_sig} + {{SW{1'b0}}, w_inc};
  assign w_frac = w_sum[SW] ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
  assign w_exp  = i_exp + {{(EW-1){1'b0}}, w_sum[SW]};

  assign w_to_inf = (i_round_mode == RM_RNE) ||
                    ((i_round_mode == RM_RUP) && !i_sign) ||
                    ((i_round_mode == RM_RDN) &&  i_sign);

  // The exponent is two's complement; its MSB marks a negative value.
  always_comb begin
    o_result    = {i_sign, w_exp[EXP_W-1:0], w_frac};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = w_lost;
    if (!w_exp[EW-1] && (w_exp >= EXP_MAX)) begin
      o_overflow = 1'b1;
      o_inexact  = 1'b1;
      o_result   = w_to_inf ? {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                            : {i_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
    end else if (w_exp[EW-1] || (w_exp == '0)) begin
      o_underflow = 1'b1;
      o_inexact   = 1'b1;
      o_result    = {i_sign, {(EXP_W+FRAC_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add significand product over
// FRAC_W+1 cycles, then one round/pack cycle; special operands finish in one cycle.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_seq_if.slave  bus
);
  localparam int W     = calc_w(EXP_W, FRAC_W);
  localparam int BIAS  = calc_bias(EXP_W);
  localparam int SW    = FRAC_W + 1;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(SW);

  state_t r_state, w_next_state;

  logic             r_sign;
  logic [1:0]       r_rm;
  logic [EW-1:0]    r_exp;
  logic [SW-1:0]    r_mcand;
  logic [SW-1:0]    r_mplier;
  logic [2*SW-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic             r_flag_invalid;
  logic             r_flag_overflow;
  logic             r_flag_underflow;
  logic             r_flag_inexact;

  logic [EXP_W-1:0]  w_a_exp, w_b_exp;
  logic [FRAC_W-1:0] w_a_frac, w_b_frac;
  fclass_t           w_a_cls, w_b_cls;
  logic              w_sign_in, w_accept, w_special;
  logic              w_in_ready, w_out_valid;
  logic [W-1:0]      w_spec_result;
  logic              w_spec_invalid;
  logic [EW-1:0]     w_exp_sum;

  assign w_a_exp  = bus.a[W-2:FRAC_W];
  assign w_b_exp  = bus.b[W-2:FRAC_W];
  assign w_a_frac = bus.a[FRAC_W-1:0];
  assign w_b_frac = bus.b[FRAC_W-1:0];
  assign w_a_cls  = classify(w_a_exp == '0, &w_a_exp, w_a_frac == '0);
  assign w_b_cls  = classify(w_b_exp == '0, &w_b_exp, w_b_frac == '0);

  assign w_sign_in = bus.a[W-1] ^ bus.b[W-1];
  assign w_special = (w_a_cls != CLS_NORM) || (w_b_cls != CLS_NORM);
  assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
  assign w_exp_sum = {2'b00, w_a_exp} + {2'b00, w_b_exp} - EW'(BIAS);

  // Special-case priority: NaN, inf*0, inf*x, 0*x.
  always_comb begin
    w_spec_result  = {w_sign_in, {(W-1){1'b0}}};
    w_spec_invalid = 1'b0;
    if ((w_a_cls == CLS_NAN) || (w_b_cls == CLS_NAN) ||
        ((w_a_cls == CLS_INF) && (w_b_cls == CLS_ZERO)) ||
        ((w_a_cls == CLS_ZERO) && (w_b_cls == CLS_INF))) begin
      w_spec_result  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      w_spec_invalid = 1'b1;
    end else if ((w_a_cls == CLS_INF) || (w_b_cls == CLS_INF)) begin
      w_spec_result = {w_sign_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next_state = w_special ? ST_DONE : ST_MUL;
      end
      ST_MUL:  if (r_cnt == CNT_W'(FRAC_W)) w_next_state = ST_RND;
      ST_RND:  w_next_state = ST_DONE;
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // LSB-first shift-add: add the multiplicand into the upper half, then shift the
  // whole accumulator right; after SW steps it holds the full 2*SW-bit product.
  logic [SW:0] w_partial;
  assign w_partial = {1'b0, r_acc[2*SW-1:SW]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

  // Product lies in [1,4): take the top SW bits from MSB or MSB-1.
  logic          w_p_msb, w_guard, w_round, w_sticky;
  logic [SW-1:0] w_rnd_sig;
  logic [EW-1:0] w_rnd_exp;
  assign w_p_msb   = r_acc[2*SW-1];
  assign w_rnd_sig = w_p_msb ? r_acc[2*SW-1:SW] : r_acc[2*SW-2:SW-1];
  assign w_guard   = w_p_msb ? r_acc[SW-1] : r_acc[SW-2];
  assign w_round   = w_p_msb ? r_acc[SW-2] : r_acc[SW-3];
  assign w_sticky  = w_p_msb ? |r_acc[SW-3:0] : |r_acc[SW-4:0];
  assign w_rnd_exp = r_exp + {{(EW-1){1'b0}}, w_p_msb};

  logic [W-1:0] w_rp_result;
  logic         w_rp_overflow, w_rp_underflow, w_rp_inexact;

  fp_round_pack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round_pack (
    .i_sign       (r_sign),
    .i_exp        (w_rnd_exp),
    .i_sig        (w_rnd_sig),
    .i_guard      (w_guard),
    .i_round      (w_round),
    .i_sticky     (w_sticky),
    .i_round_mode (r_rm),
    .o_result     (w_rp_result),
    .o_overflow   (w_rp_overflow),
    .o_underflow  (w_rp_underflow),
    .o_inexact    (w_rp_inexact)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign           <= 1'b0;
      r_rm             <= RM_RNE;
      r_exp            <= '0;
      r_mcand          <= '0;
      r_mplier         <= '0;
      r_acc            <= '0;
      r_cnt            <= '0;
      r_result         <= '0;
      r_flag_invalid   <= 1'b0;
      r_flag_overflow  <= 1'b0;
      r_flag_underflow <= 1'b0;
      r_flag_inexact   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_sign           <= w_sign_in;
          r_rm             <= bus.round_mode;
          r_exp            <= w_exp_sum;
          r_mcand          <= {1'b1, w_a_frac};
          r_mplier         <= {1'b1, w_b_frac};
          r_acc            <= '0;
          r_cnt            <= '0;
          r_result         <= w_special ? w_spec_result : '0;
          r_flag_invalid   <= w_special & w_spec_invalid;
          r_flag_overflow  <= 1'b0;
          r_flag_underflow <= 1'b0;
          r_flag_inexact   <= 1'b0;
        end
        ST_MUL: begin
          r_acc    <= {w_partial, r_acc[SW-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        ST_RND: begin
          r_result         <= w_rp_result;
          r_flag_overflow  <= w_rp_overflow;
          r_flag_underflow <= w_rp_underflow;
          r_flag_inexact   <= w_rp_inexact;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.result         = r_result;
  assign bus.flag_invalid   = r_flag_invalid;
  assign bus.flag_overflow  = r_flag_overflow;
  assign bus.flag_underflow = r_flag_underflow;
  assign bus.flag_inexact   = r_flag_inexact;

endmodule
